channel_in_acc_ctrl: RTL and testbench
======================================

Name: channel_in_acc_ctrl

Overview:
Sequencer and accumulator for the 16-input channel adder tree (channel_in_sixteen_times_acc). It admits one 16-channel group per beat into the tree and tracks each beat through the tree's fixed latency. It accumulates the tree results over all channel-in groups of an output pixel, and buffers the finished per-pixel sums in a small FIFO with valid/ready output. It sits between the multiplier-array feed and the bias/quantisation stage.

Parameters:
LANE_NUM, `PICTURE_NUM, number of SIMD lanes per beat
LANE_W, `WIDTH_DATA_OUT*2, bits per lane (two's complement)
TREE_LAT, 4, adder-tree latency in cycles (one add_simd level per cycle)
FIFO_DEPTH, 8, result FIFO entries (power of 2, >= 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_start  in  1  one-cycle pulse; latches cfg_* and starts a layer pass
cfg_group_num  in  8  channel-in groups of 16 per pixel; 0 treated as 1
cfg_pixel_num  in  16  output pixels in this pass
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the pass is complete
s_valid  in  1  upstream group beat valid (data goes straight into the tree)
s_ready  out  1  beat accepted into the tree this cycle when s_valid&s_ready
tree_sum  in  LANE_NUM*LANE_W  adder-tree data_out
m_data  out  LANE_NUM*LANE_W  per-pixel accumulated sum, lane i at [(i+1)*LANE_W-1 : i*LANE_W]
m_valid  out  1  FIFO not empty
m_ready  in  1  downstream accept

Behaviour:
- Reset values: busy=0, done=0, s_ready=0, m_valid=0, m_data=0. All counters, the FIFO and the shift register are cleared. Reset mid-pass drops all in-flight data and emits no partial result.
- FSM states are IDLE, RUN, DRAIN, FIN.
  - IDLE: on cfg_start, latch the config, zero group_cnt, pix_issued and pix_popped, then go to RUN (or DRAIN if cfg_pixel_num=0). cfg_start is ignored in any other state.
  - RUN: accept beats. group_cnt increments per beat and wraps to 0 after G-1 (G = max(cfg_group_num,1)). The beat with group_cnt=0 is "first" and the one with group_cnt=G-1 is "last". On a last beat pix_issued++. When pix_issued reaches cfg_pixel_num, go to DRAIN.
  - DRAIN: s_ready=0. When the shift register is empty, the FIFO is empty and pix_popped = cfg_pixel_num, go to FIN.
  - FIN: done=1 for exactly one cycle, busy drops in the same cycle, then go to IDLE.
- Credit rule: outstanding = pixels started - pix_popped, where a pixel starts on its first beat. In RUN, s_ready = (group_cnt!=0) || (outstanding < FIFO_DEPTH). A started pixel always completes without stall, and a FIFO push never meets a full FIFO.
- Tag pipeline: TREE_LAT-deep shift register of {vld, first, last}, loaded on each accepted beat. A tag aligns with tree_sum exactly TREE_LAT cycles after acceptance. Upstream beats need not be contiguous; bubbles propagate as vld=0.
- Accumulate at the tap when vld=1:
  - sum = first ? tree_sum : acc + tree_sum, per lane, modulo 2^LANE_W (wrap, no saturation).
  - If last, push sum to the FIFO; acc is don't-care afterwards. Otherwise acc <= sum.
  - G=1 means first and last on the same beat, so tree_sum is pushed directly.
- FIFO: push and pop in the same cycle leave the count unchanged. m_data is the head entry, registered. Entries pop on m_valid&m_ready, and each pop increments pix_popped.
- Latency: a G=1 pixel accepted at cycle t reaches m_valid at t+TREE_LAT+1.
- m_ready held low makes s_ready fall once outstanding=FIFO_DEPTH at a pixel boundary.

Decomposition:
- `PICTURE_NUM and `WIDTH_DATA_OUT come from the shared Para.v. Add `TREE_LAT_16 (=4) there so the tree and this controller share it.
- One sub-module, acc_result_fifo: a synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count.
- The FSM, credit counter, tag shift register and accumulator stay in the top module.

Test Plan:
- G=1, P=3, lanes fed 1,2,3, m_ready=1 -> m_data lanes 1,2,3 in order. Each appears TREE_LAT+1 cycles after its beat; done pulses once; busy falls with done.
- G=4, P=2, tree_sum lanes = 10,20,30,40 for pixel 0 and -5,-5,-5,-5 for pixel 1 -> outputs 100 and -20 (two's complement).
- Overflow: LANE_W-bit lane, G=2, both beats 2^(LANE_W-1)-1 -> output 2^LANE_W-2 mod 2^LANE_W, i.e. -2 signed.
- Backpressure: G=1, P=20, m_ready=0 -> s_ready falls after exactly FIFO_DEPTH=8 accepted beats. On m_ready=1 all 20 results drain in order with no loss or duplication.
- Bubbles: G=3, P=2, s_valid toggling 1,0,1,0,... -> sums still correct; done only after the final pop.
- Corners:
  - cfg_pixel_num=0 -> done 2 cycles after start with no outputs.
  - cfg_group_num=0 behaves as G=1.
  - cfg_start during busy is ignored.
  - rst asserted mid-pass -> m_valid=0, busy=0 immediately; a following pass with G=1, P=1, beat=7 yields 7.

Source files
------------

// File: rtl/channel_in_acc_ctrl_pkg.sv
// Shared types and constants for the channel-in accumulator controller.
// The widths and the tree latency carry the same values as the project-wide Para.v.
package channel_in_acc_ctrl_pkg;

  localparam int PICTURE_NUM    = 4;
  localparam int WIDTH_DATA_OUT = 8;
  localparam int TREE_LAT_16    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } acc_state_t;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } beat_tag_t;

endpackage

// File: rtl/acc_result_fifo.sv
// Small synchronous FIFO for finished per-pixel sums.
// The head entry is read straight from the storage registers.
module acc_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/channel_in_acc_ctrl.sv
// Admits 16-channel group beats into the adder tree, accumulates tree results
// per output pixel and queues finished sums behind a valid/ready port.
module channel_in_acc_ctrl
  import channel_in_acc_ctrl_pkg::*;
#(
  parameter int LANE_NUM   = PICTURE_NUM,
  parameter int LANE_W     = WIDTH_DATA_OUT * 2,
  parameter int TREE_LAT   = TREE_LAT_16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [7:0]                 cfg_group_num,
  input  logic [15:0]                cfg_pixel_num,
  output logic                       busy,
  output logic                       done,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [LANE_NUM*LANE_W-1:0] tree_sum,
  output logic [LANE_NUM*LANE_W-1:0] m_data,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int DW = LANE_NUM * LANE_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  acc_state_t state, state_nxt;

  logic [7:0]  group_last;
  logic [15:0] pixel_num;
  logic [7:0]  group_cnt;
  logic [15:0] pix_issued;
  logic [15:0] pix_started;
  logic [15:0] pix_popped;
  logic [15:0] outstanding;

  logic        pass_load;
  logic        beat_acc;
  logic        beat_first;
  logic        beat_last;
  logic        pipe_empty;

  beat_tag_t   tag_sr [TREE_LAT];
  beat_tag_t   tap;
  logic [DW-1:0] acc;
  logic [DW-1:0] sum;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign beat_acc    = s_valid && s_ready;
  assign beat_first  = (group_cnt == 8'd0);
  assign beat_last   = (group_cnt == group_last);
  // Only pixels whose first beat entered the tree hold a credit.
  assign outstanding = pix_started - pix_popped;

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < TREE_LAT; i++)
      if (tag_sr[i].vld) pipe_empty = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pass_load = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start) begin
          pass_load = 1'b1;
          state_nxt = (cfg_pixel_num == 16'd0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        s_ready = !beat_first || (outstanding < 16'(FIFO_DEPTH));
        if (beat_acc && beat_last && (pix_issued + 16'd1 == pixel_num))
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pipe_empty && fifo_empty && (pix_popped == pixel_num))
          state_nxt = ST_FIN;
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      group_last  <= '0;
      pixel_num   <= '0;
      group_cnt   <= '0;
      pix_issued  <= '0;
      pix_started <= '0;
      pix_popped  <= '0;
    end else if (pass_load) begin
      group_last  <= (cfg_group_num == 8'd0) ? 8'd0 : cfg_group_num - 8'd1;
      pixel_num   <= cfg_pixel_num;
      group_cnt   <= '0;
      pix_issued  <= '0;
      pix_started <= '0;
      pix_popped  <= '0;
    end else begin
      if (beat_acc) begin
        group_cnt <= beat_last ? 8'd0 : group_cnt + 8'd1;
        if (beat_first) pix_started <= pix_started + 16'd1;
        if (beat_last)  pix_issued  <= pix_issued + 16'd1;
      end
      if (fifo_pop) pix_popped <= pix_popped + 16'd1;
    end
  end

  // Tags ride alongside the tree so each tree_sum arrives with its own flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TREE_LAT; i++) tag_sr[i] <= '0;
    end else begin
      tag_sr[0] <= '{vld: beat_acc, first: beat_first, last: beat_last};
      for (int i = 1; i < TREE_LAT; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  assign tap = tag_sr[TREE_LAT-1];

  for (genvar l = 0; l < LANE_NUM; l++) begin : g_lane
    assign sum[l*LANE_W +: LANE_W] = tap.first ? tree_sum[l*LANE_W +: LANE_W]
                                   : acc[l*LANE_W +: LANE_W] + tree_sum[l*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         acc <= '0;
    else if (tap.vld && !tap.last)   acc <= sum;
  end

  assign fifo_push = tap.vld && tap.last;
  assign fifo_pop  = m_valid && m_ready;
  assign m_valid   = !fifo_empty;

  acc_result_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (sum),
    .pop       (fifo_pop),
    .head      (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The credit scheme guarantees room for every finished pixel.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    fifo_push |-> !fifo_full);
  a_count_le_credit: assert property (@(posedge clk) disable iff (rst)
    32'(fifo_count) <= 32'(outstanding));

endmodule

// File: tb/tb_channel_in_acc_ctrl.sv
// Self-checking bench: random and directed passes against a per-pixel sum model.
module tb_channel_in_acc_ctrl;

  localparam int LN = 4;
  localparam int LW = 16;
  localparam int TL = 4;
  localparam int FD = 8;
  localparam int DW = LN * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [7:0]    cfg_group_num;
  logic [15:0]   cfg_pixel_num;
  logic          busy;
  logic          done;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] tree_sum;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  channel_in_acc_ctrl #(
    .LANE_NUM   (LN),
    .LANE_W     (LW),
    .TREE_LAT   (TL),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_group_num (cfg_group_num),
    .cfg_pixel_num (cfg_pixel_num),
    .busy          (busy),
    .done          (done),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .tree_sum      (tree_sum),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment stand-in for the adder tree: fixed delay, garbage on bubbles.
  logic [DW-1:0] beat_data;
  logic [DW-1:0] pipe [TL];
  always @(posedge clk) begin
    pipe[0] <= (s_valid && s_ready) ? beat_data : {$urandom, $urandom};
    for (int i = 1; i < TL; i++) pipe[i] <= pipe[i-1];
  end
  assign tree_sum = pipe[TL-1];

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] stim_q [$];
  logic [DW-1:0] exp_q  [$];
  logic [DW-1:0] got_q  [$];
  int            acc_cyc [$];
  int            got_cyc [$];
  int            done_cnt, done_cyc, start_cyc, acc_at_hold;
  logic          busy_at_done, sready_at_hold;

  function automatic logic [DW-1:0] splat(input int v);
    logic [DW-1:0] r;
    for (int l = 0; l < LN; l++) r[l*LW +: LW] = v[LW-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  // Reference: each pixel is the lane-wise sum of its G beats, modulo 2^LW.
  function automatic void build_expected(input int g);
    logic [DW-1:0] v, s;
    exp_q.delete();
    for (int p = 0; p * g < stim_q.size(); p++) begin
      v = '0;
      for (int b = 0; b < g; b++) begin
        s = stim_q[p*g + b];
        for (int l = 0; l < LN; l++) v[l*LW +: LW] = v[l*LW +: LW] + s[l*LW +: LW];
      end
      exp_q.push_back(v);
    end
  endfunction

  task automatic run_pass(input int gcfg, input int pnum, input int bubble_mode,
                          input int mready_pct, input int hold, input int restart_at);
    int g, total, idx, it, done_it;
    g = (gcfg == 0) ? 1 : gcfg;
    total = g * pnum;
    idx = 0; it = 0; done_it = -1;
    got_q.delete(); got_cyc.delete(); acc_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_at_done = 1'bx; acc_at_hold = -1; sready_at_hold = 1'bx;
    build_expected(g);
    @(posedge clk); #1;
    cfg_start = 1'b1;
    cfg_group_num = gcfg[7:0];
    cfg_pixel_num = pnum[15:0];
    start_cyc = cyc;
    s_valid = 1'b0;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (m_valid && m_ready) begin got_q.push_back(m_data); got_cyc.push_back(cyc); end
      if (s_valid && s_ready) begin acc_cyc.push_back(cyc); idx++; end
      if (done) begin
        done_cnt++;
        if (done_it < 0) begin done_it = it; done_cyc = cyc; busy_at_done = busy; end
      end
      if (it == hold) begin acc_at_hold = acc_cyc.size(); sready_at_hold = s_ready; end
      it++;
      if (done_it >= 0 && it > done_it + 3) break;
      if (it > 3000) break;
      @(posedge clk); #1;
      if (it == restart_at) begin
        cfg_start = 1'b1;
        cfg_group_num = 8'd1;
        cfg_pixel_num = pnum[15:0] + 16'd3;
      end else begin
        cfg_start = 1'b0;
      end
      m_ready = (it < hold) ? 1'b0 : ($urandom_range(99) < mready_pct);
      s_valid = 1'b0;
      if (idx < total) begin
        beat_data = stim_q[idx];
        case (bubble_mode)
          1:       s_valid = it[0];
          2:       s_valid = ($urandom_range(99) >= 30);
          default: s_valid = 1'b1;
        endcase
      end
    end
    cfg_start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    n_checks++;
    if (done_it < 0) begin
      n_fail++;
      $display("FAIL pass_timeout: no done within cycle budget (G=%0d P=%0d)", gcfg, pnum);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 1'b0; cfg_group_num = '0; cfg_pixel_num = '0;
    s_valid = 1'b0; m_ready = 1'b0; beat_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_checks++; if (m_data !== '0)    begin n_fail++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_group();
    stim_q.delete();
    for (int i = 0; i < 3; i++) stim_q.push_back(splat(i + 1));
    run_pass(1, 3, 0, 100, 0, -1);
    n_checks++;
    if (got_q.size() != 3) begin n_fail++; $display("FAIL g1_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      n_checks++;
      if (got_q[i] !== splat(i + 1)) begin n_fail++; $display("FAIL g1_data[%0d]: got %h want %h", i, got_q[i], splat(i + 1)); end
      n_checks++;
      if (got_cyc[i] - acc_cyc[i] != TL + 1) begin
        n_fail++; $display("FAIL g1_latency[%0d]: got %0d want %0d", i, got_cyc[i] - acc_cyc[i], TL + 1);
      end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL g1_done_pulses: got %0d want 1", done_cnt); end
    n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL g1_busy_at_done: got %b want 0", busy_at_done); end
  endtask

  task automatic test_multi_group();
    logic [DW-1:0] v;
    stim_q.delete();
    stim_q.push_back(splat(10)); stim_q.push_back(splat(20));
    stim_q.push_back(splat(30)); stim_q.push_back(splat(40));
    for (int i = 0; i < 4; i++) stim_q.push_back(splat(-5));
    run_pass(4, 2, 0, 100, 0, -1);
    n_checks++;
    if (got_q.size() != 2) begin n_fail++; $display("FAIL g4_count: got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      v = got_q[0];
      n_checks++; if (v !== splat(100)) begin n_fail++; $display("FAIL g4_pix0: got %h want %h", v, splat(100)); end
      v = got_q[1];
      n_checks++; if (v[LW-1:0] !== 16'hFFEC) begin n_fail++; $display("FAIL g4_pix1_lane0: got %h want ffec", v[LW-1:0]); end
      n_checks++; if (v !== exp_q[1]) begin n_fail++; $display("FAIL g4_pix1: got %h want %h", v, exp_q[1]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL g4_done_pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] v;
    stim_q.delete();
    stim_q.push_back(splat(32767)); stim_q.push_back(splat(32767));
    run_pass(2, 1, 0, 100, 0, -1);
    n_checks++;
    if (got_q.size() != 1) begin n_fail++; $display("FAIL ovf_count: got %0d want 1", got_q.size()); end
    else begin
      v = got_q[0];
      n_checks++; if (v !== splat(-2)) begin n_fail++; $display("FAIL ovf_wrap: got %h want %h", v, splat(-2)); end
    end
  endtask

  task automatic test_backpressure();
    stim_q.delete();
    for (int i = 0; i < 20; i++) stim_q.push_back(rand_beat());
    run_pass(1, 20, 0, 100, 40, -1);
    n_checks++; if (acc_at_hold != FD) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", acc_at_hold, FD); end
    n_checks++; if (sready_at_hold !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready: got %b want 0", sready_at_hold); end
    n_checks++; if (got_q.size() != 20) begin n_fail++; $display("FAIL bp_count: got %0d want 20", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bubbles();
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(rand_beat());
    run_pass(3, 2, 1, 70, 0, -1);
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL bub_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bub_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    if (got_cyc.size() > 0) begin
      n_checks++;
      if (done_cyc <= got_cyc[got_cyc.size()-1]) begin
        n_fail++; $display("FAIL bub_done_after_pop: done at %0d last pop at %0d", done_cyc, got_cyc[got_cyc.size()-1]);
      end
    end
  endtask

  task automatic test_zero_pixels();
    stim_q.delete();
    run_pass(2, 0, 0, 100, 0, -1);
    n_checks++; if (done_cyc != start_cyc + 2) begin n_fail++; $display("FAIL p0_done_time: got %0d want %0d", done_cyc - start_cyc, 2); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL p0_outputs: got %0d want 0", got_q.size()); end
  endtask

  task automatic test_zero_groups();
    stim_q.delete();
    for (int i = 0; i < 3; i++) stim_q.push_back(rand_beat());
    run_pass(0, 3, 0, 100, 0, -1);
    n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL g0_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL g0_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_restart_ignored();
    stim_q.delete();
    for (int i = 0; i < 2; i++) stim_q.push_back(rand_beat());
    run_pass(1, 2, 0, 100, 0, 2);
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL rs_count: got %0d want 2", got_q.size()); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rs_done_pulses: got %0d want 1", done_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rs_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_random();
    int g, p;
    for (int r = 0; r < 6; r++) begin
      g = $urandom_range(5, 1);
      p = $urandom_range(12, 1);
      stim_q.delete();
      for (int i = 0; i < g * p; i++) stim_q.push_back(rand_beat());
      run_pass(g, p, $urandom_range(2), $urandom_range(100, 40), 0, -1);
      n_checks++;
      if (got_q.size() != p) begin n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", r, got_q.size(), p); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_data[%0d]: got %h want %h", r, i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rnd%0d_done: got %0d want 1", r, done_cnt); end
    end
  endtask

  task automatic test_reset_mid_pass();
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_group_num = 8'd1; cfg_pixel_num = 16'd5;
    @(posedge clk); #1;
    cfg_start = 1'b0; s_valid = 1'b1; beat_data = rand_beat();
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (TL + 2) @(posedge clk);
    #1;
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_m_valid: got %b want 1", m_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    stim_q.delete();
    stim_q.push_back(splat(7));
    run_pass(1, 1, 0, 100, 0, -1);
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL mid_after_count: got %0d want 1", got_q.size()); end
    else begin
      n_checks++; if (got_q[0] !== splat(7)) begin n_fail++; $display("FAIL mid_after_data: got %h want %h", got_q[0], splat(7)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_multi_group();
    test_overflow();
    test_backpressure();
    test_bubbles();
    test_zero_pixels();
    test_zero_groups();
    test_restart_ignored();
    test_random();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
